// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, state codes
// and the ALU / PC mux select values driven onto the datapath.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        RWB     = 4'd8,
        BEQ     = 4'd9,
        JUMP    = 4'd10,
        ADDIEX  = 4'd11,
        ADDIWB  = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_SEXT   = 2'b10;
    localparam logic [1:0] SRCB_SEXT_2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_retire;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_retire, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_retire, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stalls.
// Define MIPS_ADDI_EN to support addi (DECODE -> ADDIEX -> ADDIWB).
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mips_multicycle_control_if.master bus
);

    state_t state_reg, state_next;
    logic   is_store_reg, is_store_next;
    logic   illegal_reg, illegal_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RESET_S;
            is_store_reg <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            is_store_reg <= is_store_next;
            illegal_reg  <= illegal_next;
        end
    end

    // The lw/sw distinction is latched in DECODE so opcode is never re-read later.
    always_comb begin
        state_next    = state_reg;
        is_store_next = is_store_reg;
        illegal_next  = 1'b0;
        case (state_reg)
            RESET_S: state_next = FETCH;
            FETCH:   if (bus.mem_ready) state_next = DECODE;
            DECODE: begin
                is_store_next = (bus.opcode == OP_SW);
                case (bus.opcode)
                    OP_RTYPE:     state_next = EXEC;
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_BEQ:       state_next = BEQ;
                    OP_J:         state_next = JUMP;
`ifdef MIPS_ADDI_EN
                    OP_ADDI:      state_next = ADDIEX;
`endif
                    default: begin
                        state_next   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_next = is_store_reg ? MEMWR : MEMRD;
            MEMRD:   if (bus.mem_ready) state_next = MEMWB;
            MEMWB:   state_next = FETCH;
            MEMWR:   if (bus.mem_ready) state_next = FETCH;
            EXEC:    state_next = RWB;
            RWB:     state_next = FETCH;
            BEQ:     state_next = FETCH;
            JUMP:    state_next = FETCH;
`ifdef MIPS_ADDI_EN
            ADDIEX:  state_next = ADDIWB;
            ADDIWB:  state_next = FETCH;
`endif
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.instr_retire  = 1'b0;
        case (state_reg)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: bus.alu_src_b = SRCB_SEXT_2;
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_SEXT;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            MEMWB: begin
                bus.reg_write    = 1'b1;
                bus.mem_to_reg   = 1'b1;
                bus.instr_retire = 1'b1;
            end
            MEMWR: begin
                bus.mem_write    = 1'b1;
                bus.iord         = 1'b1;
                bus.instr_retire = bus.mem_ready;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                bus.reg_write    = 1'b1;
                bus.reg_dst      = 1'b1;
                bus.instr_retire = 1'b1;
            end
            BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
                bus.instr_retire  = 1'b1;
            end
            JUMP: begin
                bus.pc_write     = 1'b1;
                bus.pc_source    = PCSRC_JUMP;
                bus.instr_retire = 1'b1;
            end
`ifdef MIPS_ADDI_EN
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_SEXT;
            end
            ADDIWB: begin
                bus.reg_write    = 1'b1;
                bus.instr_retire = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.state      = state_reg;
    assign bus.illegal_op = illegal_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: table-driven instruction vectors, a mid-MEMRD reset
// sequence and randomized instruction/stall streams against a path model.
module tb_mips_multicycle_control;

    logic clk = 1'b0;
    logic reset;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_retire;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        int         fs;   // low mem_ready cycles in FETCH
        int         ms;   // low mem_ready cycles in MEMRD/MEMWR
        int         ret;  // expected retire pulses
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit pend_ill = 0;
    int retire_cnt;
    int cyc_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control word for a state code, straight from the per-state table.
    function automatic ctl_t spec_out(input logic [3:0] st, input logic rdy);
        ctl_t c;
        c = '0;
        case (st)
            4'd1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            4'd2:  c.alu_src_b = 2'b11;
            4'd3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd4:  begin c.mem_read = 1; c.iord = 1; end
            4'd5:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_retire = 1; end
            4'd6:  begin c.mem_write = 1; c.iord = 1; c.instr_retire = rdy; end
            4'd7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd8:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_retire = 1; end
            4'd9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                         c.pc_source = 2'b01; c.instr_retire = 1; end
            4'd10: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_retire = 1; end
            4'd11: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd12: begin c.reg_write = 1; c.instr_retire = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t dut_out();
        ctl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.iord          = bus.iord;
        c.mem_read      = bus.mem_read;
        c.mem_write     = bus.mem_write;
        c.ir_write      = bus.ir_write;
        c.mem_to_reg    = bus.mem_to_reg;
        c.reg_dst       = bus.reg_dst;
        c.reg_write     = bus.reg_write;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.alu_op        = bus.alu_op;
        c.pc_source     = bus.pc_source;
        c.instr_retire  = bus.instr_retire;
        return c;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
`ifdef MIPS_ADDI_EN
            6'b001000: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // One clock of the expected path: drive inputs after the falling edge, check, then let the rising edge advance.
    task automatic do_cycle(input logic [5:0] op, input logic [3:0] st, input logic rdy);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        chk("state", 32'(bus.state), 32'(st));
        chk("ctl", 32'(dut_out()), 32'(spec_out(st, rdy)));
        chk("illegal_op", 32'(bus.illegal_op), 32'(pend_ill));
        pend_ill = 0;
        retire_cnt += int'(bus.instr_retire);
        cyc_cnt++;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected state path of one instruction, given its opcode and stall counts.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input int exp_ret);
        retire_cnt = 0;
        cyc_cnt    = 0;
        for (int i = 0; i < fs; i++) do_cycle(op, 4'd1, 1'b0);
        do_cycle(op, 4'd1, 1'b1);
        do_cycle(op, 4'd2, rnd_bit());
        if (!is_legal(op)) begin
            pend_ill = 1;
        end else begin
            case (op)
                6'b000000: begin do_cycle(op, 4'd7, rnd_bit()); do_cycle(op, 4'd8, rnd_bit()); end
                6'b100011: begin
                    do_cycle(op, 4'd3, rnd_bit());
                    for (int i = 0; i < ms; i++) do_cycle(op, 4'd4, 1'b0);
                    do_cycle(op, 4'd4, 1'b1);
                    do_cycle(op, 4'd5, rnd_bit());
                end
                6'b101011: begin
                    do_cycle(op, 4'd3, rnd_bit());
                    for (int i = 0; i < ms; i++) do_cycle(op, 4'd6, 1'b0);
                    do_cycle(op, 4'd6, 1'b1);
                end
                6'b000100: do_cycle(op, 4'd9, rnd_bit());
                6'b000010: do_cycle(op, 4'd10, rnd_bit());
                default: begin do_cycle(op, 4'd11, rnd_bit()); do_cycle(op, 4'd12, rnd_bit()); end
            endcase
        end
        chk("retire_count", 32'(retire_cnt), 32'(exp_ret));
        $display("instr op=%b fetch_stall=%0d mem_stall=%0d cycles=%0d retires=%0d",
                 op, fs, ms, cyc_cnt, retire_cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];
    logic [5:0] rops[6];

    initial begin
        vecs[0] = '{6'b000000, 0, 0, 1};
        vecs[1] = '{6'b100011, 0, 3, 1};
        vecs[2] = '{6'b101011, 0, 0, 1};
        vecs[3] = '{6'b101011, 1, 2, 1};
        vecs[4] = '{6'b000100, 0, 0, 1};
        vecs[5] = '{6'b000010, 0, 0, 1};
`ifdef MIPS_ADDI_EN
        vecs[6] = '{6'b001000, 0, 0, 1};
`else
        vecs[6] = '{6'b001000, 0, 0, 0};
`endif
        vecs[7] = '{6'b111111, 0, 0, 0};
        vecs[8] = '{6'b000000, 2, 0, 1};
        vecs[9] = '{6'b100011, 0, 0, 1};
        rops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        reset         = 1'b0;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_ctl", 32'(dut_out()), 32'd0);
        chk("reset_illegal", 32'(bus.illegal_op), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].fs, vecs[i].ms, vecs[i].ret);

        // Reset asserted between edges while a load is stalled in MEMRD.
        do_cycle(6'b100011, 4'd1, 1'b1);
        do_cycle(6'b100011, 4'd2, 1'b1);
        do_cycle(6'b100011, 4'd3, 1'b1);
        do_cycle(6'b100011, 4'd4, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_state", 32'(bus.state), 32'd0);
        chk("midreset_mem_read", 32'(bus.mem_read), 32'd0);
        chk("midreset_ctl", 32'(dut_out()), 32'd0);
        @(negedge clk);
        #1;
        chk("midreset_hold", 32'(bus.state), 32'd0);
        reset    = 1'b1;
        pend_ill = 0;
        run_instr(6'b100011, 2, 1, 1);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 6) == 6) op = 6'($urandom_range(0, 63));
            else op = rops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), int'(is_legal(op)));
        end

        do_cycle(6'b000000, 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
